bla_polyline_engine: RTL and testbench

Parametrised Bresenham rasteriser that replaces the single-line BLA stage with a multi-vertex engine. It accepts up to MAX_VERT vertices per primitive and draws an open polyline or closed polygon outline. Output is a pixel-coordinate stream with valid/ready back-pressure, so the fill stage or frame-buffer writer can throttle it. It sits between the main controller (start/done) and the fill wrapper (pixel consumer).

---
 rtl/bla_polyline_engine.sv | 197 +++++++++++++++++++
 tb/tb_bla_polyline_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bla_polyline_engine.sv
// Multi-vertex Bresenham rasteriser: loads up to MAX_VERT vertices and streams the pixels of an
// open polyline or closed polygon outline with valid/ready back-pressure.
module bla_polyline_engine #(
  parameter int unsigned COORD_W  = 12,
  parameter int unsigned MAX_VERT = 8,
  parameter int unsigned VC_W     = $clog2(MAX_VERT + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               closed,
  input  logic [VC_W-1:0]    vert_count,
  input  logic               vert_valid,
  input  logic [COORD_W-1:0] vert_x,
  input  logic [COORD_W-1:0] vert_y,
  output logic               vert_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  input  logic               pix_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned IDX_W = $clog2(MAX_VERT);
  localparam int unsigned AW    = COORD_W + 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] STEP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [VC_W-1:0]    V1 = VC_W'(1);
  localparam logic [VC_W-1:0]    V2 = VC_W'(2);
  localparam logic [VC_W-1:0]    VM = VC_W'(MAX_VERT);
  localparam logic [COORD_W-1:0] C1 = COORD_W'(1);
  localparam logic [COORD_W-1:0] C2 = COORD_W'(2);

  logic [2:0]               state_q;
  logic                     closed_q;
  logic [VC_W-1:0]          n_q, ld_q, e_q;
  logic [COORD_W-1:0]       vx_q [MAX_VERT];
  logic [COORD_W-1:0]       vy_q [MAX_VERT];
  logic signed [AW-1:0]     acc_q, dx_q, dy_q;
  logic                     sx_q, sy_q;
  logic [COORD_W-1:0]       cnt_q;

  logic [VC_W-1:0]          nxt_e;
  logic                     last_edge, emit_end, count_bad, zero_len;
  logic [COORD_W-1:0]       x0, y0, x1, y1, adx, ady, s_cnt;
  logic signed [AW-1:0]     s_dx, s_dy, acc_n;
  logic signed [AW:0]       e2, dx_e, dy_e;
  logic                     step_x, step_y;
  logic [COORD_W-1:0]       nx, ny;

  assign vert_ready = (state_q == LOAD);

  // Edge geometry for SETUP, taken straight from the vertex register file.
  always_comb begin
    nxt_e     = (e_q == n_q - V1) ? '0 : e_q + V1;
    last_edge = closed_q ? (e_q == n_q - V1) : (e_q == n_q - V2);
    emit_end  = last_edge & ~closed_q;
    count_bad = (vert_count < V2) || (vert_count > VM);
    x0        = vx_q[e_q[IDX_W-1:0]];
    y0        = vy_q[e_q[IDX_W-1:0]];
    x1        = vx_q[nxt_e[IDX_W-1:0]];
    y1        = vy_q[nxt_e[IDX_W-1:0]];
    adx       = (x1 >= x0) ? x1 - x0 : x0 - x1;
    ady       = (y1 >= y0) ? y1 - y0 : y0 - y1;
    zero_len  = (adx == '0) && (ady == '0);
    // Major-axis length equals the number of steps to the end point.
    s_cnt     = (adx > ady) ? adx : ady;
    s_dx      = $signed({2'b00, adx});
    s_dy      = -$signed({2'b00, ady});
  end

  // One Bresenham step from the pixel currently presented.
  always_comb begin
    e2     = $signed({acc_q, 1'b0});
    dx_e   = $signed({dx_q[AW-1], dx_q});
    dy_e   = $signed({dy_q[AW-1], dy_q});
    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);
    acc_n  = acc_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    nx     = step_x ? (sx_q ? pix_x + C1 : pix_x - C1) : pix_x;
    ny     = step_y ? (sy_q ? pix_y + C1 : pix_y - C1) : pix_y;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      closed_q  <= 1'b0;
      n_q       <= '0;
      ld_q      <= '0;
      e_q       <= '0;
      acc_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      cnt_q     <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int unsigned i = 0; i < MAX_VERT; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count_bad) begin
              err <= 1'b1;
            end else begin
              closed_q <= closed;
              n_q      <= vert_count;
              ld_q     <= '0;
              busy     <= 1'b1;
              state_q  <= LOAD;
            end
          end
        end
        LOAD: begin
          if (vert_valid) begin
            vx_q[ld_q[IDX_W-1:0]] <= vert_x;
            vy_q[ld_q[IDX_W-1:0]] <= vert_y;
            if (ld_q == n_q - V1) begin
              e_q     <= '0;
              state_q <= SETUP;
            end else begin
              ld_q <= ld_q + V1;
            end
          end
        end
        SETUP: begin
          if (zero_len) begin
            if (last_edge) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              e_q <= e_q + V1;
            end
          end else begin
            pix_valid <= 1'b1;
            pix_x     <= x0;
            pix_y     <= y0;
            // A closed outline ends one step short of v0.
            pix_last  <= last_edge & closed_q & (s_cnt == C1);
            dx_q      <= s_dx;
            dy_q      <= s_dy;
            sx_q      <= (x0 < x1);
            sy_q      <= (y0 < y1);
            acc_q     <= s_dx + s_dy;
            cnt_q     <= s_cnt;
            state_q   <= STEP;
          end
        end
        STEP: begin
          if (pix_ready) begin
            if ((cnt_q == '0) || ((cnt_q == C1) && !emit_end)) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              if (last_edge) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= DONE;
              end else begin
                e_q     <= e_q + V1;
                state_q <= SETUP;
              end
            end else begin
              pix_x    <= nx;
              pix_y    <= ny;
              acc_q    <= acc_n;
              cnt_q    <= cnt_q - C1;
              pix_last <= last_edge & (closed_q ? (cnt_q == C2) : (cnt_q == C1));
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bla_polyline_engine.sv
// Directed bench for bla_polyline_engine: pixel sequences, pix_last, latency, back-pressure,
// error pulses, degenerate outline and mid-primitive reset.
module tb_bla_polyline_engine;

  localparam int CW = 12;
  localparam int MV = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          closed = 1'b0;
  logic [VW-1:0] vert_count = '0;
  logic          vert_valid = 1'b0;
  logic [CW-1:0] vert_x = '0;
  logic [CW-1:0] vert_y = '0;
  logic          pix_ready = 1'b0;
  logic          vert_ready, pix_valid, pix_last, busy, done, err;
  logic [CW-1:0] pix_x, pix_y;

  bla_polyline_engine #(.COORD_W(CW), .MAX_VERT(MV)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .closed     (closed),
    .vert_count (vert_count),
    .vert_valid (vert_valid),
    .vert_x     (vert_x),
    .vert_y     (vert_y),
    .vert_ready (vert_ready),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] vq[$];
  logic [23:0] ep[$];
  logic [23:0] gp[$];
  bit          gl[$];
  int          first_v, last_hs, done_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_prim(input bit c);
    start      = 1'b1;
    closed     = c;
    vert_count = VW'(vq.size());
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("vert_ready_load", vert_ready, 1);
    foreach (vq[i]) begin
      vert_valid = 1'b1;
      vert_x     = vq[i][23:12];
      vert_y     = vq[i][11:0];
      tick();
    end
    vert_valid = 1'b0;
  endtask

  task automatic collect(input bit bp, input int stop_after);
    logic [23:0] hold_p;
    bit          hold_l;
    bit          holding = 1'b0;
    bit          tgl = 1'b0;
    int          hs = 0;
    gp.delete();
    gl.delete();
    first_v = -1;
    last_hs = -1;
    done_at = -1;
    for (int i = 0; i < 300; i++) begin
      if (holding) begin
        check("stall_hold", {pix_valid, pix_last, pix_x, pix_y}, {1'b1, hold_l, hold_p});
        holding = 1'b0;
      end
      if (done) begin
        done_at = i;
        check("busy_fall", busy, 0);
        break;
      end
      if (pix_valid && first_v < 0) first_v = i;
      if (bp) begin
        if (first_v >= 0) begin
          pix_ready = tgl;
          tgl = ~tgl;
        end else begin
          pix_ready = 1'b0;
        end
      end else begin
        pix_ready = 1'b1;
      end
      if (pix_valid && pix_ready) begin
        gp.push_back({pix_x, pix_y});
        gl.push_back(pix_last);
        last_hs = i;
        hs++;
      end else if (pix_valid) begin
        holding = 1'b1;
        hold_p  = {pix_x, pix_y};
        hold_l  = pix_last;
      end
      tick();
      if (stop_after > 0 && hs == stop_after) break;
    end
    pix_ready = 1'b1;
    if (stop_after == 0 && done_at < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_pixels(input string tag);
    check({tag, "_count"}, gp.size(), ep.size());
    for (int i = 0; i < ep.size() && i < gp.size(); i++) begin
      check({tag, "_pix"}, gp[i], ep[i]);
      check({tag, "_last"}, gl[i], (i == ep.size() - 1));
    end
  endtask

  task automatic set_case1();
    vq = '{{12'd0, 12'd0}, {12'd5, 12'd2}};
    ep = '{{12'd0, 12'd0}, {12'd1, 12'd0}, {12'd2, 12'd1}, {12'd3, 12'd1},
           {12'd4, 12'd2}, {12'd5, 12'd2}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    check("reset_outputs", {vert_ready, pix_valid, pix_last, busy, done, err, pix_x, pix_y}, 0);
    tick();
    n_rst = 1'b1;
    tick();

    // Open line, full throughput
    set_case1();
    send_prim(1'b0);
    collect(1'b0, 0);
    check_pixels("open");
    check("first_lat", first_v, 1);
    check("done_lat", done_at, last_hs + 1);
    check("throughput", last_hs - first_v + 1, 6);
    tick();

    // Closed triangle
    vq = '{{12'd0, 12'd0}, {12'd3, 12'd0}, {12'd0, 12'd3}};
    ep = '{{12'd0, 12'd0}, {12'd1, 12'd0}, {12'd2, 12'd0}, {12'd3, 12'd0}, {12'd2, 12'd1},
           {12'd1, 12'd2}, {12'd0, 12'd3}, {12'd0, 12'd2}, {12'd0, 12'd1}};
    send_prim(1'b1);
    collect(1'b0, 0);
    check_pixels("tri");
    check("tri_done_lat", done_at, last_hs + 1);
    tick();

    // Back-pressure 0101.. from the first valid cycle
    set_case1();
    send_prim(1'b0);
    collect(1'b1, 0);
    check_pixels("bp");
    check("bp_cycles", last_hs - first_v + 1, 12);
    check("bp_done_lat", done_at, last_hs + 1);
    tick();

    // Invalid counts
    start = 1'b1; vert_count = 4'd1; vert_valid = 1'b1;
    tick();
    start = 1'b0;
    check("err_low", err, 1);
    check("err_low_busy", busy, 0);
    check("err_low_vready", vert_ready, 0);
    tick();
    check("err_pulse", err, 0);
    check("err_low_vready2", vert_ready, 0);
    vert_valid = 1'b0;
    start = 1'b1; vert_count = 4'd9;
    tick();
    start = 1'b0;
    check("err_high", err, 1);
    check("err_high_busy", busy, 0);
    tick();

    // Closed, all vertices identical
    vq = '{{12'd7, 12'd7}, {12'd7, 12'd7}};
    ep.delete();
    send_prim(1'b1);
    collect(1'b0, 0);
    check_pixels("degen");
    check("degen_done", done_at >= 0, 1);
    tick();

    // Steep, negative direction
    vq = '{{12'd10, 12'd10}, {12'd8, 12'd4}};
    ep = '{{12'd10, 12'd10}, {12'd10, 12'd9}, {12'd9, 12'd8}, {12'd9, 12'd7},
           {12'd9, 12'd6}, {12'd8, 12'd5}, {12'd8, 12'd4}};
    send_prim(1'b0);
    collect(1'b0, 0);
    check_pixels("steep");
    tick();

    // Coordinates at the top of the range
    vq = '{{12'd4092, 12'd4095}, {12'd4095, 12'd4093}};
    ep = '{{12'd4092, 12'd4095}, {12'd4093, 12'd4094}, {12'd4094, 12'd4094},
           {12'd4095, 12'd4093}};
    send_prim(1'b0);
    collect(1'b0, 0);
    check_pixels("maxc");
    tick();

    // Reset after the third pixel, then a clean run
    set_case1();
    send_prim(1'b0);
    collect(1'b0, 3);
    check("pre_rst_count", gp.size(), 3);
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_outputs", {vert_ready, pix_valid, pix_last, busy, done, err, pix_x, pix_y}, 0);
    tick();
    n_rst = 1'b1;
    tick();
    check("rst_idle_done", done, 0);
    set_case1();
    send_prim(1'b0);
    collect(1'b0, 0);
    check_pixels("after_rst");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
